fifo_arb_ctrl: RTL and testbench
================================

FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDRBITS, default 4, giving depth 2**ADDRBITS (16 entries).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: req0_valid  input  1  requester 0 has a word to push.
REQ-006 SHALL have port: req0_data  input  WIDTH  requester 0 word.
REQ-007 SHALL have port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_data and req1_ready, identical in form to requester 0.
REQ-009 SHALL have port: pop  input  1  consumer read request.
REQ-010 SHALL have port: rd_valid  output  1  memory readdata valid in this cycle.
REQ-011 SHALL have port: underflow  output  1  one-cycle pulse for pop while empty.
REQ-012 SHALL have port: mem_writeenable  output  1  memory write strobe.
REQ-013 SHALL have port: mem_writedata  output  WIDTH  memory write data.
REQ-014 SHALL have ports mem_writeaddr and mem_readaddr  output  ADDRBITS+1 each, with MSB tied to 0.
REQ-015 SHALL have port: mem_readenable  output  1  memory read strobe.
REQ-016 SHALL have ports: full  output  1; empty  output  1; count  output  ADDRBITS+1  occupancy 0..16.

Function
REQ-017 SHALL keep write and read pointers of ADDRBITS+1 bits, with the MSB used as the wrap bit; mem_*addr SHALL equal {1'b0, ptr[ADDRBITS-1:0]}.
REQ-018 SHALL assert full when the pointer MSBs differ and the low bits are equal, and empty when the pointers are equal; both flags are registered state at the start of the cycle.
REQ-019 SHALL, when full=0, grant at most one requester per cycle: if only one is valid, grant it; if both are valid, grant the one not granted last.
REQ-020 SHALL make the first contention after reset go to requester 0.
REQ-021 SHALL update the last-grant register only on an actual grant.
REQ-022 SHALL drive reqN_ready combinationally as (grant to N); a requester not granted SHALL see ready=0 and must hold valid and data.
REQ-023 SHALL, on a grant, assert mem_writeenable in the same cycle with mem_writedata = the granted reqN_data; wptr increments at the clock edge.
REQ-024 SHALL drive all ready outputs to 0 and mem_writeenable to 0 while full=1, even if a pop occurs in the same cycle.
REQ-025 SHALL accept a pop when pop=1 and empty=0: assert mem_readenable that cycle, increment rptr, and assert rd_valid exactly one cycle later, because the memory has 1-cycle read latency.
REQ-026 SHALL ignore a pop while empty=1, including when a push occurs in the same cycle; the ignored pop SHALL assert underflow for one cycle and change no state.
REQ-027 SHALL, on a simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-028 SHALL let pointers wrap from 2*depth-1 to 0 with no special handling.
REQ-029 SHALL never overwrite an unread entry and never read an unwritten entry.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear wptr, rptr, count, last-grant (to req1, so req0 wins first), rd_valid and underflow.
REQ-031 SHALL hold empty=1, full=0, all ready outputs, mem_writeenable and mem_readenable at 0 during reset.
REQ-032 SHALL discard all queued entries and any pending rd_valid on a reset assertion mid-operation.
REQ-033 SHALL, after reset release, accept a grant on the first rising clk edge.

Verification
REQ-034 SHALL pass: req0 pushes 16 words 0x1..0x10 -> full=1 after the 16th edge, count=16, and req0_ready=0 on the 17th attempt.
REQ-035 SHALL pass: both requesters valid for 4 cycles from reset, empty FIFO -> grants go 0,1,0,1 and mem_writeaddr goes 0,1,2,3.
REQ-036 SHALL pass: pop on empty -> underflow=1 for one cycle, mem_readenable=0, and count stays 0.
REQ-037 SHALL pass: 20 pushes interleaved with 20 pops -> data out in order, and the write address goes 15 then 0 with the wrap bit toggling.
REQ-038 SHALL pass: full FIFO with pop and req0_valid in the same cycle -> req0_ready=0, count=15, and rd_valid=1 on the next cycle.
REQ-039 SHALL pass: reset asserted with count=5 and a pop outstanding -> rd_valid=0 immediately, then empty=1 and count=0.

Source files
------------

// File: rtl/fifo_arb_ctrl_if.sv
// Requester, consumer and memory-port bundle for fifo_arb_ctrl.
// slave is the controller's side; master is the requesters/consumer/memory side.
interface fifo_arb_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 4
);
    logic                req0_valid;
    logic [WIDTH-1:0]    req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [WIDTH-1:0]    req1_data;
    logic                req1_ready;
    logic                pop;
    logic                rd_valid;
    logic                underflow;
    logic                mem_writeenable;
    logic [WIDTH-1:0]    mem_writedata;
    logic [ADDRBITS:0]   mem_writeaddr;
    logic [ADDRBITS:0]   mem_readaddr;
    logic                mem_readenable;
    logic                full;
    logic                empty;
    logic [ADDRBITS:0]   count;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, pop,
        output req0_ready, req1_ready, rd_valid, underflow,
               mem_writeenable, mem_writedata, mem_writeaddr, mem_readaddr,
               mem_readenable, full, empty, count
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, pop,
        input  req0_ready, req1_ready, rd_valid, underflow,
               mem_writeenable, mem_writedata, mem_writeaddr, mem_readaddr,
               mem_readenable, full, empty, count
    );
endinterface

// File: rtl/fifo_arb_ctrl.sv
// Two-requester round-robin FIFO controller driving an external 1-cycle-latency memory.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module fifo_arb_ctrl #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    fifo_arb_ctrl_if.slave  bus
);
    localparam int PW = ADDRBITS + 1;

    logic [PW-1:0]    wptr, rptr;
    logic             last_grant;
    logic             rd_valid_q, underflow_q;
    logic             full, empty;
    logic             grant0, grant1, push, pop_ok;
    logic [WIDTH-1:0] wdata;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDRBITS] != rptr[ADDRBITS]) &&
                   (wptr[ADDRBITS-1:0] == rptr[ADDRBITS-1:0]);

    // Contention goes to whoever did not win last; last_grant=1 out of reset so req0 wins first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset && !full) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        end
    end

    assign push   = grant0 | grant1;
    assign pop_ok = reset && bus.pop && !empty;
    assign wdata  = grant1 ? bus.req1_data : bus.req0_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            last_grant  <= 1'b1;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr       <= wptr + 1'b1;
                last_grant <= grant1;
            end
            if (pop_ok)
                rptr <= rptr + 1'b1;
            rd_valid_q  <= pop_ok;
            underflow_q <= bus.pop && empty;
        end
    end

    assign bus.req0_ready      = grant0;
    assign bus.req1_ready      = grant1;
    assign bus.mem_writeenable = push;
    assign bus.mem_writedata   = wdata;
    assign bus.mem_writeaddr   = {1'b0, wptr[ADDRBITS-1:0]};
    assign bus.mem_readaddr    = {1'b0, rptr[ADDRBITS-1:0]};
    assign bus.mem_readenable  = pop_ok;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.underflow       = underflow_q;
    assign bus.full            = full;
    assign bus.empty           = empty;
    assign bus.count           = wptr - rptr;
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl with a small 1-cycle-latency memory model on the mem port.
module tb_fifo_arb_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fifo_arb_ctrl_if #(.WIDTH(32), .ADDRBITS(4)) bus ();

    fifo_arb_ctrl #(.WIDTH(32), .ADDRBITS(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:31];
    logic [31:0] rdata;

    always @(posedge clk) begin
        if (bus.mem_writeenable) mem[bus.mem_writeaddr] <= bus.mem_writedata;
        if (bus.mem_readenable)  rdata <= mem[bus.mem_readaddr];
    end

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.pop        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.pop        = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %0h expected 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got %0h expected 0", bus.full); end
        checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got %0h expected 0", bus.count); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %0h%0h expected 00", bus.req0_ready, bus.req1_ready); end
        checks++; if (bus.mem_writeenable !== 1'b0) begin failures++; $display("FAIL reset_we got %0h expected 0", bus.mem_writeenable); end
        checks++; if (bus.mem_readenable !== 1'b0) begin failures++; $display("FAIL reset_re got %0h expected 0", bus.mem_readenable); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_rdv_uf got %0h%0h expected 00", bus.rd_valid, bus.underflow); end
    endtask

    task automatic test_arb();
        logic exp_g [0:5];
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.req0_data = 32'hA0;
        bus.req1_data = 32'hB1;
        for (int k = 0; k < 6; k++) begin
            bus.req0_valid = (k != 4);
            bus.req1_valid = 1'b1;
            #1;
            checks++;
            if (bus.req0_ready !== !exp_g[k] || bus.req1_ready !== exp_g[k]) begin
                failures++; $display("FAIL arb_grant[%0d] got r0=%0h r1=%0h expected grant to %0d", k, bus.req0_ready, bus.req1_ready, exp_g[k]);
            end
            checks++;
            if (bus.mem_writeaddr !== 5'(k) || bus.mem_writedata !== (exp_g[k] ? 32'hB1 : 32'hA0)) begin
                failures++; $display("FAIL arb_write[%0d] got addr %0h data %0h expected addr %0h", k, bus.mem_writeaddr, bus.mem_writedata, k);
            end
            @(posedge clk); #1;
        end
        idle();
        checks++; if (bus.count !== 5'd6) begin failures++; $display("FAIL arb_count got %0h expected 6", bus.count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 32'(i);
            #1;
            checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got %0h expected 1", i, bus.req0_ready); end
            if (i == 16) begin
                checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL fill_full15 got %0h expected 0", bus.full); end
            end
            @(posedge clk); #1;
        end
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got %0h expected 1", bus.full); end
        checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL fill_count got %0h expected 16", bus.count); end
        bus.req0_data = 32'h11;
        #1;
        checks++; if (bus.req0_ready !== 1'b0 || bus.mem_writeenable !== 1'b0) begin failures++; $display("FAIL fill_17th got ready %0h we %0h expected 0 0", bus.req0_ready, bus.mem_writeenable); end
    endtask

    task automatic test_full_pop();
        bus.req0_valid = 1'b1;
        bus.pop        = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b0 || bus.mem_writeenable !== 1'b0) begin failures++; $display("FAIL fullpop_ready got %0h we %0h expected 0 0", bus.req0_ready, bus.mem_writeenable); end
        checks++; if (bus.mem_readenable !== 1'b1 || bus.mem_readaddr !== 5'd0) begin failures++; $display("FAIL fullpop_re got %0h addr %0h expected 1 0", bus.mem_readenable, bus.mem_readaddr); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.count !== 5'd15) begin failures++; $display("FAIL fullpop_count got %0h expected 15", bus.count); end
        checks++; if (bus.rd_valid !== 1'b1 || rdata !== 32'h1) begin failures++; $display("FAIL fullpop_rd got v %0h data %0h expected 1 1", bus.rd_valid, rdata); end
        @(posedge clk); #1;
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL fullpop_rd_drop got %0h expected 0", bus.rd_valid); end
    endtask

    task automatic test_underflow();
        do_reset();
        bus.pop = 1'b1;
        #1;
        checks++; if (bus.mem_readenable !== 1'b0) begin failures++; $display("FAIL uf_re got %0h expected 0", bus.mem_readenable); end
        @(posedge clk); #1;
        checks++; if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin failures++; $display("FAIL uf_pulse got uf %0h count %0h expected 1 0", bus.underflow, bus.count); end
        // pop while empty plus a push: push lands, pop is still ignored
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h55;
        #1;
        checks++; if (bus.mem_readenable !== 1'b0 || bus.req0_ready !== 1'b1) begin failures++; $display("FAIL uf_push got re %0h ready %0h expected 0 1", bus.mem_readenable, bus.req0_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.underflow !== 1'b1 || bus.count !== 5'd1 || bus.rd_valid !== 1'b0) begin failures++; $display("FAIL uf_push_state got uf %0h count %0h rdv %0h expected 1 1 0", bus.underflow, bus.count, bus.rd_valid); end
        @(posedge clk); #1;
        checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got %0h expected 0", bus.underflow); end
    endtask

    task automatic test_wrap();
        logic [4:0] ea;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            bus.req0_valid = (k < 20);
            bus.req0_data  = 32'h100 + 32'(k);
            bus.pop        = (k > 0);
            #1;
            if (k == 15 || k == 16) begin
                ea = 5'(k % 16);
                checks++; if (bus.mem_writeaddr !== ea) begin failures++; $display("FAIL wrap_addr[%0d] got %0h expected %0h", k, bus.mem_writeaddr, ea); end
            end
            @(posedge clk); #1;
            if (k == 14 || k == 15) begin
                checks++; if (dut.wptr[4] !== (k == 15)) begin failures++; $display("FAIL wrap_bit[%0d] got %0h expected %0h", k, dut.wptr[4], (k == 15)); end
            end
            if (k > 0) begin
                checks++;
                if (bus.rd_valid !== 1'b1 || rdata !== 32'h100 + 32'(k - 1)) begin
                    failures++; $display("FAIL wrap_data[%0d] got v %0h data %0h expected 1 %0h", k, bus.rd_valid, rdata, 32'h100 + 32'(k - 1));
                end
            end
        end
        idle();
        checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL wrap_end got count %0h empty %0h expected 0 1", bus.count, bus.empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 32'h200 + 32'(i);
            @(posedge clk); #1;
        end
        idle();
        bus.pop = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.count !== 5'd5 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got count %0h rdv %0h expected 5 1", bus.count, bus.rd_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rdv got %0h expected 0", bus.rd_valid); end
        checks++; if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.mem_readenable !== 1'b0) begin failures++; $display("FAIL mid_clear got empty %0h count %0h re %0h expected 1 0 0", bus.empty, bus.count, bus.mem_readenable); end
        do_reset();
        @(posedge clk); #1;
        checks++; if (bus.count !== 5'd0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL mid_after got count %0h uf %0h expected 0 0", bus.count, bus.underflow); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_arb();
        test_fill();
        test_full_pop();
        test_underflow();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
